// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 4-stage CPU: start/halt sequencing,
// load-use stalls, branch/jump flushes, halt drain and saturating perf counters.
module pipe_ctrl #(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             halt_n,
  output logic             pc_en,
  output logic             decode_stall,
  output logic             flush_fetch,
  output logic             flush_decode,
  output logic             bubble,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STALL  = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4,
    HALTED = 3'd5
  } state_t;

  localparam logic [2:0]       STALL_LOAD = 3'(LOAD_USE_STALL - 1);
  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [2:0]       DRAIN_LOAD = 3'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) sat_inc = v;
    else              sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_r, state_nxt_s;
  logic [2:0]        cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]  cycle_r, stall_r, redir_r;
  logic              clr_s, cyc_inc_s, stall_inc_s, redir_inc_s, branch_s;

  // State register and shared stall/flush/drain down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and same-cycle control outputs; a taken branch overrides the
  // per-state behaviour in RUN, STALL and FLUSH.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    pc_en        = 1'b0;
    decode_stall = 1'b0;
    flush_fetch  = 1'b0;
    flush_decode = 1'b0;
    bubble       = 1'b0;
    running      = 1'b0;
    halted       = 1'b0;
    clr_s        = 1'b0;
    cyc_inc_s    = 1'b0;
    stall_inc_s  = 1'b0;
    redir_inc_s  = 1'b0;
    branch_s     = branch_taken & ((state_r == RUN) | (state_r == STALL) | (state_r == FLUSH));
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        running   = 1'b1;
        pc_en     = 1'b1;
        cyc_inc_s = 1'b1;
        if (jump) begin
          flush_fetch = 1'b1;
        end else if (!halt_n) begin
          pc_en        = 1'b0;
          flush_fetch  = 1'b1;
          flush_decode = 1'b1;
          cnt_nxt_s    = DRAIN_LOAD;
          state_nxt_s  = DRAIN;
        end else if (load_use) begin
          pc_en        = 1'b0;
          decode_stall = 1'b1;
          bubble       = 1'b1;
          stall_inc_s  = 1'b1;
          if (LOAD_USE_STALL > 1) begin
            cnt_nxt_s   = STALL_LOAD;
            state_nxt_s = STALL;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      STALL: begin
        running      = 1'b1;
        cyc_inc_s    = 1'b1;
        decode_stall = 1'b1;
        bubble       = 1'b1;
        stall_inc_s  = 1'b1;
        if (cnt_r <= 3'd1) begin
          cnt_nxt_s   = 3'd0;
          state_nxt_s = RUN;
        end else begin
          cnt_nxt_s   = cnt_r - 3'd1;
        end
      end
      FLUSH: begin
        running      = 1'b1;
        cyc_inc_s    = 1'b1;
        pc_en        = 1'b1;
        flush_decode = 1'b1;
        if (cnt_r <= 3'd1) begin
          cnt_nxt_s   = 3'd0;
          state_nxt_s = RUN;
        end else begin
          cnt_nxt_s   = cnt_r - 3'd1;
        end
      end
      DRAIN: begin
        running     = 1'b1;
        cyc_inc_s   = 1'b1;
        flush_fetch = 1'b1;
        bubble      = 1'b1;
        if (cnt_r <= 3'd1) begin
          cnt_nxt_s   = 3'd0;
          state_nxt_s = HALTED;
        end else begin
          cnt_nxt_s   = cnt_r - 3'd1;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (start) begin
          state_nxt_s = RUN;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
    if (branch_s) begin
      pc_en        = 1'b1;
      flush_fetch  = 1'b1;
      flush_decode = 1'b1;
      decode_stall = 1'b0;
      bubble       = 1'b0;
      stall_inc_s  = 1'b0;
      redir_inc_s  = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        cnt_nxt_s   = FLUSH_LOAD;
        state_nxt_s = FLUSH;
      end else begin
        cnt_nxt_s   = 3'd0;
        state_nxt_s = RUN;
      end
    end else begin
      redir_inc_s = (state_r == RUN) & jump;
    end
  end

  // Saturating performance counters, cleared when execution (re)starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_r <= {CNT_W{1'b0}};
      stall_r <= {CNT_W{1'b0}};
      redir_r <= {CNT_W{1'b0}};
    end else if (clr_s) begin
      cycle_r <= {CNT_W{1'b0}};
      stall_r <= {CNT_W{1'b0}};
      redir_r <= {CNT_W{1'b0}};
    end else begin
      cycle_r <= cyc_inc_s   ? sat_inc(cycle_r) : cycle_r;
      stall_r <= stall_inc_s ? sat_inc(stall_r) : stall_r;
      redir_r <= redir_inc_s ? sat_inc(redir_r) : redir_r;
    end
  end

  assign cycle_cnt    = cycle_r;
  assign stall_cnt    = stall_r;
  assign redirect_cnt = redir_r;

endmodule
